display_page_scheduler: RTL
===========================

// Module: display_page_scheduler
// PURPOSE
//   Time-shares the 4-digit seven-segment display between up to four 16-bit
//   requesters (e.g. PC, instruction word, register probe, status).
//   Round-robin arbitrates, snapshots the winner's value and holds it on the
//   digit outputs for a fixed dwell period, then rotates.
//   Outputs feed the iwData0..3 nibble inputs of the display driver.
// PARAMETERS
//   pDwellCycles  512  wNewClk cycles each granted page is shown; legal range >= 1
// PORTS
//   wNewClk   in   1   clock
//   iwnRst    in   1   reset, asynchronous, active-low
//   iwReq     in   4   per-source display request; level, bit i = source i
//   iwData    in   64  source i value on iwData[16*i+15:16*i]; stable while iwReq[i]=1
//   iwHold    in   1   freeze: stops dwell countdown and suppresses new grants
//   owAck     out  4   one-hot, 1-cycle pulse; snapshot of source i taken
//   owData0   out  4   digit 0 nibble = snapshot[3:0]
//   owData1   out  4   digit 1 nibble = snapshot[7:4]
//   owData2   out  4   digit 2 nibble = snapshot[11:8]
//   owData3   out  4   digit 3 nibble = snapshot[15:12]
//   owSrc     out  2   index of the source currently shown
//   owActive  out  1   1 while a page is being shown (SHOW state)
// BEHAVIOUR
//   Reset (async, iwnRst=0): state IDLE; owAck=0, owData0..3=0, owSrc=0,
//     owActive=0, dwell counter=0, RR pointer=0. All outputs are registered.
//   Arbitration: winner = first i with iwReq[i]=1, scanning from RR pointer
//     upward mod 4. On grant: pointer <= winner+1 (mod 4).
//   Grant edge (registered): snapshot iwData of winner -> owData0..3,
//     owSrc <= winner, owAck[winner] <= 1 for exactly one cycle,
//     owActive <= 1, counter <= pDwellCycles-1, state <= SHOW.
//   IDLE: grant when |iwReq && !iwHold; otherwise stay.
//   SHOW: if iwHold, counter and state frozen, no ack.
//     Else if counter!=0, counter decrements.
//     Else (counter==0): if |iwReq, grant back-to-back (no bubble cycle).
//     Else state <= IDLE, owActive <= 0.
//   Dwell: each page is shown for exactly pDwellCycles unheld cycles,
//     measured from the grant edge.
//   IDLE retains the last owData/owSrc values; the display keeps showing
//     the last page, and owActive=0 flags it stale.
//   The request is a level. A requester that keeps iwReq high is re-granted
//     in its round-robin turn and receives a new owAck each time.
//     Dropping iwReq mid-dwell does not disturb the shown page.
//   A sole requester is re-granted every pDwellCycles cycles.
//   pDwellCycles=1: a new grant every cycle while requests persist.
//   Counter width $clog2(pDwellCycles+1); no wrap.
//   Requests that change on the grant edge: the sampled value is used.
//   Reset asserted mid-dwell: immediate return to reset values.
//     The first grant after reset starts from source 0.
// TESTING
//   T1 reset: iwnRst=0 mid-SHOW -> all outputs 0, state IDLE, same cycle (async).
//   T2 single: iwReq=4'b0100, src2=16'hBEEF, pDwellCycles=4 -> owAck=4'b0100
//      pulse; owData3..0=B,E,E,F; owSrc=2; owActive=1; re-ack every 4 cycles.
//   T3 rotation: iwReq=4'b1111, src i = 16'h1111*i -> owSrc 0,1,2,3,0,...;
//      one ack per 4 cycles; no bubble between pages.
//   T4 hold: iwHold=1 for 10 cycles mid-dwell -> page held 4+10 cycles;
//      no ack during hold; countdown resumes exactly where it stopped.
//   T5 drain: iwReq=4'b0001 dropped after first ack -> after 4 cycles
//      owActive=0, owData still shows src0 value, no further ack.
//   T6 fairness: iwReq=4'b1001 with src0 always requesting -> sources 0 and 3
//      alternate; neither source is granted twice in a row.

Source files
------------

// File: rtl/display_page_scheduler.sv
// display_page_scheduler
//   Round-robin time-sharing of the 4-digit seven-segment display between
//   up to four 16-bit requesters. The winner's value is snapshotted and held
//   on the digit outputs for pDwellCycles cycles, then the next requester in
//   round-robin order is granted. All outputs are registered.
module display_page_scheduler #(
    parameter int unsigned pDwellCycles = 512
) (
    input  logic        wNewClk,
    input  logic        iwnRst,
    input  logic [3:0]  iwReq,
    input  logic [63:0] iwData,
    input  logic        iwHold,
    output logic [3:0]  owAck,
    output logic [3:0]  owData0,
    output logic [3:0]  owData1,
    output logic [3:0]  owData2,
    output logic [3:0]  owData3,
    output logic [1:0]  owSrc,
    output logic        owActive
);

    localparam int unsigned    CW         = $clog2(pDwellCycles + 1);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(pDwellCycles - 1);

    localparam logic IDLE = 1'b0;
    localparam logic SHOW = 1'b1;

    logic          state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [1:0]    src_q,   src_d;
    logic [15:0]   data_q,  data_d;
    logic [3:0]    ack_q,   ack_d;

    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic          grant;

    // Round-robin pick: first requesting source scanning upward from ptr_q.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_vld && iwReq[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant from IDLE, or back-to-back when the current dwell has expired.
    always_comb begin
        grant = !iwHold && win_vld && ((state_q == IDLE) || (cnt_q == '0));
    end

    // Next-state: snapshot on grant, otherwise count down or drain to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        ack_d   = '0;
        if (grant) begin
            state_d        = SHOW;
            cnt_d          = DWELL_LAST;
            ptr_d          = win_idx + 2'd1;
            src_d          = win_idx;
            data_d         = iwData[{win_idx, 4'b0000} +: 16];
            ack_d[win_idx] = 1'b1;
        end else if (!iwHold && (state_q == SHOW)) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wNewClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign owAck    = ack_q;
    assign owSrc    = src_q;
    assign owActive = (state_q == SHOW);
    assign owData0  = data_q[3:0];
    assign owData1  = data_q[7:4];
    assign owData2  = data_q[11:8];
    assign owData3  = data_q[15:12];

endmodule
